// File: rtl/tpu_host_driver.sv
// tpu_host_driver: sequences one 2x2 job into a byte-serial TPU.
// The driver streams four weight bytes and four input bytes to the TPU,
// waits READ_DELAY cycles, collects four 16-bit results and holds them
// for the host until the result handshake completes.
// Optional feature: define TPU_HOST_STAT_EN to select stationary-weights
// mode. In that mode the TPU returns each 16-bit result in one cycle, on
// tpu_uo_out and tpu_uio_out together, so the read phase is 4 cycles.
module tpu_host_driver #(
  parameter int READ_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_weights,
  input  logic [31:0] cmd_inputs,
  input  logic [2:0]  cmd_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  input  logic [7:0]  tpu_uio_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_READ = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Last count value of the LOAD and WAIT phases. A zero delay never
  // enters WAIT, so WAIT_LAST is unused in that case.
  localparam logic [3:0] LOAD_LAST = 4'd7;
  localparam logic [3:0] WAIT_LAST = (READ_DELAY == 0) ? 4'd0 : 4'(READ_DELAY - 1);

`ifdef TPU_HOST_STAT_EN
  localparam logic [3:0] READ_LAST = 4'd3;
  localparam logic       STAT_MODE = 1'b1;
`else
  localparam logic [3:0] READ_LAST = 4'd7;
  localparam logic       STAT_MODE = 1'b0;
  // The second result byte lane only matters in stationary mode.
  logic uio_out_unused;
  assign uio_out_unused = ^tpu_uio_out;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] weights_q, weights_d;
  logic [31:0] inputs_q, inputs_d;
  logic [2:0]  flags_q, flags_d;
  logic [63:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;

  logic        active;
  logic [63:0] load_bytes;

  // State register and datapath flops; reset discards any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      weights_q   <= 32'd0;
      inputs_q    <= 32'd0;
      flags_q     <= 3'd0;
      res_data_q  <= 64'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      weights_q   <= weights_d;
      inputs_q    <= inputs_d;
      flags_q     <= flags_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state logic: one shared counter paces LOAD, WAIT and READ.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    weights_d   = weights_q;
    inputs_d    = inputs_q;
    flags_d     = flags_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          weights_d = cmd_weights;
          inputs_d  = cmd_inputs;
          flags_d   = cmd_flags;
          cnt_d     = 4'd0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = 4'd0;
          state_d = (READ_DELAY == 0) ? S_READ : S_WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_READ: begin
`ifdef TPU_HOST_STAT_EN
        // One whole result per cycle: c_j = {uo, uio_out}.
        res_data_d[{cnt_q[1:0], 4'b0000} +: 16] = {tpu_uo_out, tpu_uio_out};
`else
        // Even cycles carry the high byte of c(j/2), odd cycles the low byte.
        res_data_d[{cnt_q[2:1], ~cnt_q[0], 3'b000} +: 8] = tpu_uo_out;
`endif
        if (cnt_q == READ_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        // res_valid rises on the first DONE cycle edge, so the capture
        // register has settled before the host can see it.
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cnt_d       = 4'd0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // Output decode from the registered state; data bus is quiet outside LOAD.
  always_comb begin
    active     = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_READ);
    load_bytes = {inputs_q, weights_q};
    tpu_ui_in  = 8'd0;
    if (state_q == S_LOAD) begin
      tpu_ui_in = load_bytes[{cnt_q[2:0], 3'b000} +: 8];
    end
    tpu_uio_in = {2'b00,
                  active & STAT_MODE,
                  active,
                  active ? flags_q : 3'b000,
                  (state_q == S_LOAD)};
    cmd_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    res_valid  = res_valid_q;
    res_data   = res_data_q;
  end

endmodule

// File: tb/tb_tpu_host_driver.sv
// tb_tpu_host_driver: two driver instances (READ_DELAY 2 and 0) with a
// behavioural TPU that returns table bytes during the read phase.
// Results go through a scoreboard; control bytes are checked per cycle.
module tb_tpu_host_driver;

`ifdef TPU_HOST_STAT_EN
  localparam bit STAT     = 1'b1;
  localparam int BASE_LAT = 13;
  localparam int NREAD    = 4;
`else
  localparam bit STAT     = 1'b0;
  localparam int BASE_LAT = 17;
  localparam int NREAD    = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst         [2];
  logic        cmd_valid   [2];
  logic        cmd_ready   [2];
  logic [31:0] cmd_weights [2];
  logic [31:0] cmd_inputs  [2];
  logic [2:0]  cmd_flags   [2];
  logic        res_valid   [2];
  logic        res_ready   [2];
  logic [63:0] res_data    [2];
  logic [7:0]  tpu_ui_in   [2];
  logic [7:0]  tpu_uio_in  [2];
  logic [7:0]  tpu_uo_out  [2];
  logic [7:0]  tpu_uio_out [2];
  logic        busy        [2];

  logic [63:0] rd_bytes [2];
  int          acc_edge [2];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  function automatic int rd_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h required %h", name, i, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [63:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic pop_exp(input int i, output logic [63:0] v, output bit ok);
    v  = '0;
    ok = 1'b0;
    if (i == 0) begin
      if (exp_q0.size() > 0) begin ok = 1'b1; v = exp_q0.pop_front(); end
    end else begin
      if (exp_q1.size() > 0) begin ok = 1'b1; v = exp_q1.pop_front(); end
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int RD = (gi == 0) ? 2 : 0;

      tpu_host_driver #(.READ_DELAY(RD)) u_dut (
        .clk         (clk),
        .rst         (rst[gi]),
        .cmd_valid   (cmd_valid[gi]),
        .cmd_ready   (cmd_ready[gi]),
        .cmd_weights (cmd_weights[gi]),
        .cmd_inputs  (cmd_inputs[gi]),
        .cmd_flags   (cmd_flags[gi]),
        .res_valid   (res_valid[gi]),
        .res_ready   (res_ready[gi]),
        .res_data    (res_data[gi]),
        .tpu_ui_in   (tpu_ui_in[gi]),
        .tpu_uio_in  (tpu_uio_in[gi]),
        .tpu_uo_out  (tpu_uo_out[gi]),
        .tpu_uio_out (tpu_uio_out[gi]),
        .busy        (busy[gi])
      );

      // Accelerator model: counts cycles since the last load byte and
      // presents read byte j during read cycle j.
      initial begin
        int post;
        int j;
        post = 0;
        tpu_uo_out[gi]  = 8'h00;
        tpu_uio_out[gi] = 8'hEE;
        forever begin
          @(negedge clk);
          if (tpu_uio_in[gi][0])      post = 0;
          else if (tpu_uio_in[gi][4]) post = post + 1;
          else                        post = 0;
          j = post - 1 - RD;
          tpu_uo_out[gi]  = 8'h00;
          tpu_uio_out[gi] = 8'hEE;
          if (post > 0 && j >= 0 && j < NREAD) begin
            if (STAT) begin
              tpu_uo_out[gi]  = rd_bytes[gi][16*j +: 8];
              tpu_uio_out[gi] = rd_bytes[gi][16*j+8 +: 8];
            end else begin
              tpu_uo_out[gi]  = rd_bytes[gi][8*j +: 8];
            end
          end
        end
      end

      // Result monitor: compares data and latency on each new res_valid.
      initial begin
        bit          seen;
        bit          ok;
        logic [63:0] e;
        seen = 1'b0;
        forever begin
          @(negedge clk);
          if (res_valid[gi] && !seen) begin
            seen = 1'b1;
            pop_exp(gi, e, ok);
            if (!ok) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_result dut%0d: got %h required no result", gi, res_data[gi]);
            end else begin
              chk("result_data", gi, res_data[gi], e);
              chk("result_latency", gi, 64'(cyc - acc_edge[gi]), 64'(RD + BASE_LAT));
            end
          end else if (!res_valid[gi]) begin
            seen = 1'b0;
          end
        end
      end
    end
  endgenerate

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_cmd_ready"}, i, 64'(cmd_ready[i]), 64'd1);
    chk({tag, "_res_valid"}, i, 64'(res_valid[i]), 64'd0);
    chk({tag, "_busy"},      i, 64'(busy[i]),      64'd0);
    chk({tag, "_ui_in"},     i, 64'(tpu_ui_in[i]), 64'd0);
    chk({tag, "_uio_in"},    i, 64'(tpu_uio_in[i]), 64'd0);
  endtask

  // One job: offer, check every LOAD cycle, await result, hold, consume.
  // abort_at >= 0 pulses reset in that LOAD cycle and expects no result.
  task automatic run_job(input int i, input logic [31:0] w, input logic [31:0] in,
                         input logic [2:0] f, input logic [63:0] b, input logic [63:0] exp,
                         input int hold, input int abort_at);
    int t;
    logic [7:0] eb;
    rd_bytes[i] = b;
    t = 0;
    @(negedge clk);
    while (!cmd_ready[i] && t < 50) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", i, 64'(cmd_ready[i]), 64'd1);
    if (abort_at < 0) push_exp(i, exp);
    cmd_weights[i] = w;
    cmd_inputs[i]  = in;
    cmd_flags[i]   = f;
    cmd_valid[i]   = 1'b1;
    @(posedge clk);
    #1;
    acc_edge[i]    = cyc;
    cmd_valid[i]   = 1'b0;
    cmd_weights[i] = 32'h0;
    cmd_inputs[i]  = 32'h0;
    cmd_flags[i]   = 3'b000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        rst[i] = 1'b1;
        #1;
        chk("rst_res_data", i, res_data[i], 64'd0);
        chk("rst_busy", i, 64'(busy[i]), 64'd0);
        chk("rst_ui_in", i, 64'(tpu_ui_in[i]), 64'd0);
        chk("rst_uio_in", i, 64'(tpu_uio_in[i]), 64'd0);
        @(negedge clk);
        rst[i] = 1'b0;
        @(negedge clk);
        chk_idle(i, "after_rst");
        return;
      end
      eb = (k < 4) ? w[8*k +: 8] : in[8*(k-4) +: 8];
      chk($sformatf("load_byte%0d", k), i, 64'(tpu_ui_in[i]), 64'(eb));
      chk($sformatf("load_ctrl%0d", k), i, 64'(tpu_uio_in[i]), 64'({2'b00, STAT, 1'b1, f, 1'b1}));
    end
    @(negedge clk);
    chk("post_load_ctrl", i, 64'(tpu_uio_in[i]), 64'({2'b00, STAT, 1'b1, f, 1'b0}));
    chk("post_load_ui", i, 64'(tpu_ui_in[i]), 64'd0);
    t = 0;
    while (!res_valid[i] && t < 40) begin @(negedge clk); t++; end
    chk("res_valid_wait", i, 64'(res_valid[i]), 64'd1);
    for (int h = 0; h < hold; h++) begin
      cmd_valid[i] = (h % 2 == 0);
      @(negedge clk);
      chk("hold_valid", i, 64'(res_valid[i]), 64'd1);
      chk("hold_data", i, res_data[i], exp);
      chk("hold_cmd_ready", i, 64'(cmd_ready[i]), 64'd0);
      chk("hold_uio_in", i, 64'(tpu_uio_in[i]), 64'd0);
    end
    cmd_valid[i] = 1'b0;
    res_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    res_ready[i] = 1'b0;
    @(negedge clk);
    chk_idle(i, "after_done");
    $display("[TB] dut%0d job w=%h in=%h flags=%b expected %h", i, w, in, f, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]         = 1'b1;
      cmd_valid[i]   = 1'b0;
      cmd_weights[i] = 32'h0;
      cmd_inputs[i]  = 32'h0;
      cmd_flags[i]   = 3'b000;
      res_ready[i]   = 1'b0;
      rd_bytes[i]    = 64'h0;
      acc_edge[i]    = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("reset_res_data", i, res_data[i], 64'd0);
    for (int i = 0; i < 2; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_idle(i, "reset");

    // Basic job, long result stall with ignored cmd_valid pulses.
    run_job(0, 32'h04030201, 32'h08070605, 3'b000,
            64'h3200_2B00_1600_1300, 64'h0032_002B_0016_0013, 10, -1);
    // Reset in LOAD cycle 3 discards the job.
    run_job(0, 32'hDDCCBBAA, 32'h44332211, 3'b010,
            64'hF0DE_BC9A_7856_3412, 64'h0, 0, 3);
    // Follow-up job after the reset completes normally.
    run_job(0, 32'hDDCCBBAA, 32'h44332211, 3'b010,
            64'hF0DE_BC9A_7856_3412, 64'hDEF0_9ABC_5678_1234, 0, -1);
    // Zero read delay: READ follows LOAD directly.
    run_job(1, 32'h0D0C0B0A, 32'h01020304, 3'b101,
            64'h0807_0605_0403_0201, 64'h0708_0506_0304_0102, 2, -1);
    run_job(1, 32'h80FF7F00, 32'h00010203, 3'b011,
            64'h0000_FFFF_8001_7F00, 64'h0000_FFFF_0180_007F, 0, -1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 0, 64'(exp_q0.size()), 64'd0);
    chk("scoreboard_empty", 1, 64'(exp_q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_host_driver.md
TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

Interface
REQ-001 Parameter: READ_DELAY, default 2, idle cycles between last load byte and first result capture (range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cmd_valid  input  1  host offers a job.
REQ-005 cmd_ready  output  1  driver accepts a job; high only in IDLE.
REQ-006 cmd_weights  input  32  weight0..3; byte k is bits [8k+7:8k].
REQ-007 cmd_inputs  input  32  input0..3; same byte order.
REQ-008 cmd_flags  input  3  {elemwise, activation, transpose}, bit 0 is transpose.
REQ-009 res_valid  output  1  result held on res_data.
REQ-010 res_ready  input  1  host consumes the result.
REQ-011 res_data  output  64  c00..c11; c_i is bits [16i+15:16i].
REQ-012 tpu_ui_in  output  8  data byte driven to the accelerator.
REQ-013 tpu_uio_in  output  8  control byte: [0] load_en, [1] transpose, [2] activation, [3] elemwise, [4] enable, [5] stat_weights, [7:6] zero.
REQ-014 tpu_uo_out  input  8  result byte from the accelerator.
REQ-015 tpu_uio_out  input  8  result low byte; used only in stationary mode.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, LOAD, WAIT, READ, DONE; a single 4-bit counter cnt sequences LOAD, WAIT and READ.
REQ-018 IDLE: cmd_valid && cmd_ready latches weights, inputs and flags, clears cnt, and moves to LOAD.
REQ-019 LOAD lasts exactly 8 cycles, with load_en=1 and enable=1.
REQ-020 LOAD data: in cycle k, tpu_ui_in = weight byte k for k<4 and input byte k-4 for k>=4.
REQ-021 WAIT lasts READ_DELAY cycles, with load_en=0 and enable=1.
REQ-022 READ_DELAY=0 skips WAIT: LOAD goes straight to READ.
REQ-023 READ lasts 8 cycles with enable=1.
REQ-024 READ capture: at the edge ending READ cycle j, tpu_uo_out is stored as the high byte of c(j/2) for even j and as the low byte for odd j.
REQ-025 After READ the driver enters DONE with res_valid=1; res_data is stable until the handshake.
REQ-026 DONE: res_valid && res_ready returns to IDLE; with res_ready low the driver stays in DONE indefinitely.
REQ-027 No new command is accepted before the result is consumed; at least one IDLE cycle always separates jobs.
REQ-028 Flag bits [3:1] of tpu_uio_in show the latched flags during LOAD, WAIT and READ, and are 0 in IDLE and DONE.
REQ-029 tpu_ui_in is 0 outside LOAD.
REQ-030 cmd_valid outside IDLE is ignored and has no effect on state.
REQ-031 Accept-to-res_valid latency is 17+READ_DELAY cycles (8 non-stationary); 13+READ_DELAY in stationary mode.

Reset
REQ-032 rst asserted at any time, including mid-job, forces IDLE immediately and clears cnt, the latched operands and res_data.
REQ-033 Reset values of outputs: cmd_ready=1 after release, res_valid=0, busy=0, res_data=0, tpu_ui_in=0, tpu_uio_in=0.
REQ-034 A job interrupted by reset is discarded and produces no result.

Configuration
REQ-035 Macro TPU_HOST_STAT_EN defined: stat_weights (tpu_uio_in[5]) is 1 during LOAD, WAIT and READ.
REQ-036 With TPU_HOST_STAT_EN, READ lasts 4 cycles; in cycle j, c_j = {tpu_uo_out, tpu_uio_out}.
REQ-037 Macro TPU_HOST_STAT_EN undefined: stat_weights is tied to 0, tpu_uio_out is unused, and READ is the 8-cycle byte-serial form.

Verification
REQ-038 Weights 01,02,03,04 and inputs 05,06,07,08, flags=0: tpu_ui_in sequence 01..08 over 8 consecutive cycles with load_en high only in those cycles.
REQ-039 READ bytes 00,13,00,16,00,2B,00,32 -> res_data = 0x0032_002B_0016_0013, with res_valid exactly 19 cycles after the accept edge (READ_DELAY=2).
REQ-040 res_ready held low for 10 cycles -> res_valid and res_data remain stable and cmd_ready stays 0; cmd_valid pulses in this window are ignored.
REQ-041 rst pulsed in LOAD cycle 3 -> all outputs return to reset values; a following job with weights AA,BB,CC,DD completes normally.
REQ-042 flags=3'b101, READ_DELAY=0 -> tpu_uio_in = 0x1B in LOAD and 0x1A in READ; READ begins immediately after LOAD.
REQ-043 With TPU_HOST_STAT_EN, READ pairs {12,34},{56,78},{9A,BC},{DE,F0} -> res_data = 0xDEF0_9ABC_5678_1234, with tpu_uio_in[5]=1 while busy.
